// File: rtl/set_assoc_cache_ctrl.sv
// rtl/set_assoc_cache_ctrl.sv - N-way set-associative write-through read cache with tree-PLRU and miss FSM
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W    = 19,
  parameter int LINE_W    = 64,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int SETS   = 1 << SETS_LOG2;
  localparam int TAG_W  = ADDR_W - OFF_W - SETS_LOG2;
  localparam int WAY_W  = (WAYS > 2) ? 2 : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FILL     = 2'd1;
  localparam logic [1:0] S_FILL_RSP = 2'd2;
  localparam logic [1:0] S_WRITE    = 2'd3;

  generate
    if (WAYS != 2 && WAYS != 4) begin : g_bad_ways
      $error("set_assoc_cache_ctrl: WAYS must be 2 or 4");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_mem_rd_req;
  logic              r_mem_wr_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [WAYS-1:0]   r_valid [SETS];
  logic [2:0]        r_plru  [SETS];
  logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
  logic [LINE_W-1:0] r_data  [WAYS][SETS];

  logic [SETS_LOG2-1:0] w_req_idx;
  logic [TAG_W-1:0]     w_req_tag;
  logic [WSEL_W-1:0]    w_req_wsel;
  logic [SETS_LOG2-1:0] w_lat_idx;
  logic [TAG_W-1:0]     w_lat_tag;
  logic [WSEL_W-1:0]    w_lat_wsel;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic [LINE_W-1:0]    w_hit_line;
  logic [31:0]          w_hit_word;
  logic [WAY_W-1:0]     w_vic;
  logic [31:0]          w_fill_word;
  logic                 w_accept;
  logic                 w_unused;

  assign w_req_idx = req_addr[OFF_W +: SETS_LOG2];
  assign w_req_tag = req_addr[ADDR_W-1 -: TAG_W];
  assign w_lat_idx = r_addr[OFF_W +: SETS_LOG2];
  assign w_lat_tag = r_addr[ADDR_W-1 -: TAG_W];

  generate
    if (WORDS > 1) begin : g_wsel
      assign w_req_wsel = req_addr[OFF_W-1:2];
      assign w_lat_wsel = r_addr[OFF_W-1:2];
    end else begin : g_wsel_one
      assign w_req_wsel = '0;
      assign w_lat_wsel = '0;
    end
  endgenerate

  assign w_unused = ^{req_addr[1:0], r_addr[1:0]};

  // PLRU bits point at the least-recently-used side: bit0 is the root (or the only bit for 2 ways),
  // bit1 picks within ways {0,1}, bit2 within ways {2,3}.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [WAY_W-1:0] w);
    logic [2:0] n;
    logic [1:0] w2;
    n  = p;
    w2 = 2'(w);
    if (WAYS == 2) begin
      n[0] = ~w2[0];
    end else begin
      n[0] = ~w2[1];
      if (w2[1]) n[2] = ~w2[0];
      else       n[1] = ~w2[0];
    end
    return n;
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_hit && r_valid[w_req_idx][w] && (r_tag[w][w_req_idx] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  assign w_hit_line  = r_data[w_hit_way][w_req_idx];
  assign w_hit_word  = w_hit_line[{w_req_wsel, 5'b0} +: 32];
  assign w_fill_word = mem_rdata[{w_lat_wsel, 5'b0} +: 32];

  // Victim: lowest invalid way first, otherwise follow the PLRU pointers.
  always_comb begin
    logic       found;
    logic [2:0] p;
    found = 1'b0;
    w_vic = '0;
    p     = r_plru[w_lat_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !r_valid[w_lat_idx][w]) begin
        found = 1'b1;
        w_vic = WAY_W'(w);
      end
    end
    if (!found) begin
      if (WAYS == 2) w_vic = WAY_W'(p[0]);
      else           w_vic = WAY_W'({p[0], p[0] ? p[2] : p[1]});
    end
  end

  assign w_accept  = (r_state == S_IDLE) && !flush && req_valid;
  assign req_ready = (r_state == S_IDLE) && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_mem_rd_req <= 1'b0;
      r_mem_wr_req <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
          end else if (req_valid) begin
            r_addr <= req_addr;
            if (!req_we) begin
              if (w_hit) begin
                r_rsp_valid          <= 1'b1;
                r_rsp_rdata          <= w_hit_word;
                r_plru[w_req_idx]    <= plru_touch(r_plru[w_req_idx], w_hit_way);
              end else begin
                r_mem_rd_req <= 1'b1;
                r_mem_addr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_state      <= S_FILL;
              end
            end else begin
              if (w_hit) r_plru[w_req_idx] <= plru_touch(r_plru[w_req_idx], w_hit_way);
              r_mem_wr_req <= 1'b1;
              r_mem_addr   <= req_addr;
              r_mem_wdata  <= req_wdata;
              r_state      <= S_WRITE;
            end
          end
        end
        S_FILL: begin
          if (mem_rvalid) begin
            r_valid[w_lat_idx][w_vic] <= 1'b1;
            r_plru[w_lat_idx]         <= plru_touch(r_plru[w_lat_idx], w_vic);
            r_mem_rd_req              <= 1'b0;
            r_rsp_valid               <= 1'b1;
            r_rsp_rdata               <= w_fill_word;
            r_state                   <= S_FILL_RSP;
          end
        end
        S_FILL_RSP: r_state <= S_IDLE;
        S_WRITE: begin
          if (mem_ack) begin
            r_mem_wr_req <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_rdata  <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide whether its contents are trusted.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && w_hit)
      r_data[w_hit_way][w_req_idx][{w_req_wsel, 5'b0} +: 32] <= req_wdata;
    if (r_state == S_FILL && mem_rvalid) begin
      r_data[w_vic][w_lat_idx] <= mem_rdata;
      r_tag[w_vic][w_lat_idx]  <= w_lat_tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_accept && !req_we) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign mem_rd_req = r_mem_rd_req;
  assign mem_wr_req = r_mem_wr_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
